cpu_pc_seq: RTL
===============

Name: cpu_pc_seq

Overview:
- Parametrised program-counter sequencer that replaces the bare PC register.
- Owns next-PC selection: increment, branch, jump, call/return through an internal return-address stack (RAS), and single-level interrupt entry/exit.
- Provides halt/resume control.
- Sits between decode/execute redirect signals and instruction fetch; drives the fetch address every cycle.

Parameters:
- PC_W, 16, PC and target width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- IRQ_VEC, 16'h0010, PC loaded on interrupt entry.
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- halt_req  in  1  request transition to HALT.
- resume  in  1  leave HALT.
- branch_taken  in  1  conditional branch resolved taken.
- branch_tgt  in  PC_W  branch target.
- jump  in  1  unconditional jump.
- call  in  1  jump to jump_tgt and push return address.
- jump_tgt  in  PC_W  jump/call target.
- ret  in  1  pop RAS into PC.
- irq_req  in  1  level interrupt request.
- reti  in  1  return from interrupt.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  high in RUN.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- irq_active  out  1  inside interrupt handler.
- ras_ovf  out  1  sticky: push while full.
- ras_unf  out  1  sticky: pop while empty.

Behaviour:
- Reset (rst high at posedge, overrides everything):
  - pc=RESET_VEC, state=RUN, pc_valid=1.
  - irq_ack=0, irq_active=0, RAS emptied, ras_ovf=ras_unf=0, epc=0.
- States: RUN, HALT.
  - RUN→HALT on halt_req (not stalled); pc holds.
  - HALT→RUN on resume, next cycle; pc unchanged.
  - In HALT all redirect/irq inputs are ignored; pc_valid=0.
- stall=1 in RUN: pc, RAS, epc, state all hold. Redirect inputs ignored; the producer must hold them. irq_ack stays 0.
- Next-PC priority in RUN, not stalled, highest first:
  - halt_req: hold pc, go to HALT.
  - reti: pc=epc, irq_active=0. Ignored if irq_active=0.
  - irq_req with irq_active=0: epc=seq_pc (the pc the increment path would have produced), pc=IRQ_VEC, irq_ack=1 for one cycle, irq_active=1.
  - ret: pc=RAS top, pop.
  - call: push pc+1, pc=jump_tgt.
  - jump: pc=jump_tgt.
  - branch_taken: pc=branch_tgt.
  - default: pc=pc+1.
- The winning event alone takes effect; lower-priority inputs that cycle are dropped.
- Latency: redirect takes effect on the next posedge. pc is a registered output.
- Arithmetic: pc+1 is modulo 2^PC_W; all-ones wraps to 0.
- While irq_active=1, irq_req is ignored. Nesting is not supported.
- RAS:
  - Push when full overwrites the oldest entry (circular) and sets ras_ovf. Depth stays RAS_DEPTH.
  - Pop when empty: pc=pc+1, ras_unf set, pointer unchanged.
  - ras_ovf and ras_unf clear only on reset.
  - call and ret never coincide in effect; ret wins by priority.
- Reset mid-handler or mid-stall returns to the reset state; RAS contents are discarded.

Decomposition:
- cpu_pc_pkg: state enum (RUN, HALT); next-PC source enum (SEQ, BR, JMP, CALL, RET, IRQ, RETI, HOLD); default width constant.
- Sub-module cpu_ras:
  - Parametrised by PC_W and RAS_DEPTH.
  - Holds the circular buffer, pointer, and count.
  - push/pop/clear inputs; top, full, empty outputs.

Test Plan:
- Reset with RESET_VEC=0x0100, idle 3 cycles → pc=0x0100, 0x0101, 0x0102; pc_valid=1. Start at pc=0xFFFF → next pc=0x0000.
- At pc=0x0020, call with jump_tgt=0x0200 → pc=0x0200. Three increments, then ret → pc=0x0021.
- Nine calls with RAS_DEPTH=8 → ras_ovf=1. Eight rets return the newest 8 addresses. Ninth ret → ras_unf=1, pc increments.
- At pc=0x0040, irq_req=1 together with branch_taken (tgt 0x0300) → pc=0x0010, irq_ack one pulse, epc=0x0041. Second irq_req ignored. reti → pc=0x0041, irq_active=0.
- stall held 4 cycles with jump asserted → pc frozen; jump applies on the first unstalled cycle.
- halt_req at pc=0x0055 → pc_valid=0, pc=0x0055 held through irq_req. resume → RUN, pc=0x0055 then 0x0056. rst asserted mid-HALT → pc=RESET_VEC.

Source files
------------

// File: rtl/cpu_pc_pkg.sv
// Shared types for the program-counter sequencer: run state, next-PC source
// selection and the default address width.
package cpu_pc_pkg;

  localparam int unsigned PcWidthDefault = 16;

  typedef enum logic {
    StRun,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    SrcSeq,
    SrcBr,
    SrcJmp,
    SrcCall,
    SrcRet,
    SrcIrq,
    SrcReti,
    SrcHold
  } pc_src_e;

endpackage

// File: rtl/cpu_ras.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// a pop while empty is refused here and reported by the caller.
module cpu_ras #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [PtrW-1:0] top_idx;

  // ptr_q names the next free slot; when full that slot holds the oldest entry.
  assign top_idx = ptr_q - PtrW'(1);
  assign top     = mem_q[top_idx];
  assign full    = (cnt_q == (PtrW + 1)'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (!full) begin
        cnt_d = cnt_q + (PtrW + 1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
    cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer: prioritised next-PC selection, return-address
// stack, single-level interrupt entry/exit and halt/resume control.
module cpu_pc_seq
  import cpu_pc_pkg::*;
#(
  parameter int unsigned     PC_W      = PcWidthDefault,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] IRQ_VEC   = 'h0010,
  parameter int unsigned     RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_tgt,
  input  logic            jump,
  input  logic            call,
  input  logic [PC_W-1:0] jump_tgt,
  input  logic            ret,
  input  logic            irq_req,
  input  logic            reti,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            irq_ack,
  output logic            irq_active,
  output logic            ras_ovf,
  output logic            ras_unf
);

  state_e          state_q, state_d;
  pc_src_e         src;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [PC_W-1:0] seq_pc;
  logic            irq_active_q, irq_active_d;
  logic            irq_ack_q, irq_ack_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;

  assign seq_pc = pc_q + PC_W'(1);

  cpu_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .clear     (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Source selection: only one event wins per cycle, the rest are dropped.
  always_comb begin
    src     = SrcHold;
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        StRun: begin
          if (halt_req) begin
            src     = SrcHold;
            state_d = StHalt;
          end else if (reti && irq_active_q) begin
            src = SrcReti;
          end else if (irq_req && !irq_active_q) begin
            src = SrcIrq;
          end else if (ret) begin
            src = SrcRet;
          end else if (call) begin
            src = SrcCall;
          end else if (jump) begin
            src = SrcJmp;
          end else if (branch_taken) begin
            src = SrcBr;
          end else begin
            src = SrcSeq;
          end
        end
        StHalt: begin
          if (resume) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    irq_active_d = irq_active_q;
    irq_ack_d    = 1'b0;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    unique case (src)
      SrcSeq:  pc_d = seq_pc;
      SrcBr:   pc_d = branch_tgt;
      SrcJmp:  pc_d = jump_tgt;
      SrcCall: begin
        pc_d     = jump_tgt;
        ras_push = 1'b1;
        if (ras_full) begin
          ovf_d = 1'b1;
        end
      end
      SrcRet: begin
        if (ras_empty) begin
          pc_d  = seq_pc;
          unf_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end
      SrcIrq: begin
        epc_d        = seq_pc;
        pc_d         = IRQ_VEC;
        irq_ack_d    = 1'b1;
        irq_active_d = 1'b1;
      end
      SrcReti: begin
        pc_d         = epc_q;
        irq_active_d = 1'b0;
      end
      SrcHold: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      pc_q         <= RESET_VEC;
      epc_q        <= '0;
      irq_active_q <= 1'b0;
      irq_ack_q    <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      irq_active_q <= irq_active_d;
      irq_ack_q    <= irq_ack_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = (state_q == StRun);
  assign irq_ack    = irq_ack_q;
  assign irq_active = irq_active_q;
  assign ras_ovf    = ovf_q;
  assign ras_unf    = unf_q;

endmodule
